// File: rtl/fat32_pkg.sv
// -----------------------------------------------------------------------------
// fat32_pkg
//   Shared constants for the FAT32 volume parser: byte offsets of the fields
//   captured from an MBR / volume boot record, accepted partition type codes,
//   error codes reported on o_err_code, FSM state encoding and a small helper
//   used by the boot-record validity checks.
// -----------------------------------------------------------------------------
package fat32_pkg;

  // Byte offsets inside a 512-byte boot block (fields are little-endian)
  localparam int OFF_BPS   = 11;   // bytes per sector, 2 bytes
  localparam int OFF_SPC   = 13;   // sectors per cluster, 1 byte
  localparam int OFF_RSVD  = 14;   // reserved sector count, 2 bytes
  localparam int OFF_NFATS = 16;   // number of FAT copies, 1 byte
  localparam int OFF_FATSZ = 36;   // FAT size in sectors (FAT32), 4 bytes
  localparam int OFF_ROOT  = 44;   // root directory first cluster, 4 bytes
  localparam int OFF_PTYPE = 450;  // first partition entry: type byte
  localparam int OFF_PLBA  = 454;  // first partition entry: start LBA, 4 bytes
  localparam int OFF_SIG   = 510;  // boot signature, 2 bytes

  // Accepted FAT32 partition type codes (CHS and LBA variants)
  localparam logic [7:0]  PTYPE_FAT32_CHS = 8'h0B;
  localparam logic [7:0]  PTYPE_FAT32_LBA = 8'h0C;

  // Boot signature 0x55 at 510, 0xAA at 511, read as a little-endian word
  localparam logic [15:0] BOOT_SIG = 16'hAA55;
  localparam logic [15:0] BPS_REQ  = 16'd512;

  // o_err_code values
  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_SHORT = 3'd1;
  localparam logic [2:0] ERR_SIG   = 3'd2;
  localparam logic [2:0] ERR_PTYPE = 3'd3;
  localparam logic [2:0] ERR_BPS   = 3'd4;
  localparam logic [2:0] ERR_SPC   = 3'd5;
  localparam logic [2:0] ERR_NFATS = 3'd6;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RECV    = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_CALC_D1 = 3'd3;
  localparam logic [2:0] ST_CALC_D2 = 3'd4;
  localparam logic [2:0] ST_FIN     = 3'd5;
  localparam logic [2:0] ST_ERR     = 3'd6;

  // Nonzero power of two: exactly one bit set
  function automatic logic is_pow2(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/fat32_le_capture.sv
// -----------------------------------------------------------------------------
// fat32_le_capture
//   Captures an NBYTES-wide little-endian field from a byte stream. The byte
//   presented while i_cnt equals OFFSET+k lands in byte lane k of o_field.
// Ports
//   i_clk    clock
//   i_rst    asynchronous active-high reset (field -> 0)
//   i_clear  synchronous clear at the start of a new parse
//   i_en     byte_in is valid and inside the block
//   i_cnt    offset of the current byte within the block
//   i_byte   current byte
//   o_field  captured field value
// -----------------------------------------------------------------------------
module fat32_le_capture #(
  parameter int OFFSET = 0,
  parameter int NBYTES = 1,
  parameter int CNT_W  = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic [CNT_W-1:0]      i_cnt,
  input  logic [7:0]            i_byte,
  output logic [8*NBYTES-1:0]   o_field
);

  // Field register: load the matching byte lane when the offset is hit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_field <= '0;
    end else if (i_clear) begin
      o_field <= '0;
    end else if (i_en) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (i_cnt == CNT_W'(OFFSET + k)) begin
          o_field[8*k +: 8] <= i_byte;
        end
      end
    end
  end

endmodule

// File: rtl/fat32_volume_parser.sv
// -----------------------------------------------------------------------------
// fat32_volume_parser
//   Consumes one 512-byte MBR or volume boot record from the SD byte stream,
//   validates it and computes the LBAs the FAT32 controller needs. Results are
//   registered and held until the next successful parse.
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start, i_mode     start pulse; mode sampled with it (0 = MBR, 1 = VBR)
//   i_byte_in/_valid    byte stream from the SD controller
//   i_block_done        end-of-block strobe
//   o_busy              parse in progress
//   o_done, o_error     1-cycle result pulses
//   o_err_code          failure reason, held until the next start
//   o_part_lba          partition start LBA (MBR mode)
//   o_sec_per_clus      sectors per cluster (VBR mode)
//   o_fat_start_lba     part_lba + reserved sectors
//   o_data_start_lba    fat_start_lba + num_fats * fat_size
//   o_root_cluster      root directory first cluster
// -----------------------------------------------------------------------------
module fat32_volume_parser
  import fat32_pkg::*;
#(
  parameter int BLOCK_BYTES = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_valid,
  input  logic        i_block_done,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [2:0]  o_err_code,
  output logic [31:0] o_part_lba,
  output logic [7:0]  o_sec_per_clus,
  output logic [31:0] o_fat_start_lba,
  output logic [31:0] o_data_start_lba,
  output logic [31:0] o_root_cluster
);

  localparam int               CNT_W    = $clog2(BLOCK_BYTES) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_BYTES);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_fat;
  logic [31:0]      r_data;

  logic             w_start_ok;
  logic             w_cap_en;
  logic             w_busy_nxt;
  logic [2:0]       w_chk_code;
  logic [31:0]      w_add_a;
  logic [31:0]      w_add_b;
  logic [31:0]      w_sum;

  logic [15:0]      w_bps;
  logic [7:0]       w_spc;
  logic [15:0]      w_rsvd;
  logic [7:0]       w_nfats;
  logic [31:0]      w_fatsz;
  logic [31:0]      w_root;
  logic [7:0]       w_ptype;
  logic [31:0]      w_plba;
  logic [15:0]      w_sig;

  // Start is honoured whenever no parse is in flight (IDLE, FIN or ERR)
  assign w_start_ok = i_start && !r_busy;
  // Bytes past the end of the block leave the counter and fields untouched
  assign w_cap_en   = (r_state == ST_RECV) && i_byte_valid && (r_cnt < CNT_FULL);

  fat32_le_capture #(.OFFSET(OFF_BPS),   .NBYTES(2), .CNT_W(CNT_W)) u_cap_bps (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(w_start_ok), .i_en(w_cap_en),
    .i_cnt(r_cnt), .i_byte(i_byte_in), .o_field(w_bps));
  fat32_le_capture #(.OFFSET(OFF_SPC),   .NBYTES(1), .CNT_W(CNT_W)) u_cap_spc (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(w_start_ok), .i_en(w_cap_en),
    .i_cnt(r_cnt), .i_byte(i_byte_in), .o_field(w_spc));
  fat32_le_capture #(.OFFSET(OFF_RSVD),  .NBYTES(2), .CNT_W(CNT_W)) u_cap_rsvd (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(w_start_ok), .i_en(w_cap_en),
    .i_cnt(r_cnt), .i_byte(i_byte_in), .o_field(w_rsvd));
  fat32_le_capture #(.OFFSET(OFF_NFATS), .NBYTES(1), .CNT_W(CNT_W)) u_cap_nfats (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(w_start_ok), .i_en(w_cap_en),
    .i_cnt(r_cnt), .i_byte(i_byte_in), .o_field(w_nfats));
  fat32_le_capture #(.OFFSET(OFF_FATSZ), .NBYTES(4), .CNT_W(CNT_W)) u_cap_fatsz (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(w_start_ok), .i_en(w_cap_en),
    .i_cnt(r_cnt), .i_byte(i_byte_in), .o_field(w_fatsz));
  fat32_le_capture #(.OFFSET(OFF_ROOT),  .NBYTES(4), .CNT_W(CNT_W)) u_cap_root (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(w_start_ok), .i_en(w_cap_en),
    .i_cnt(r_cnt), .i_byte(i_byte_in), .o_field(w_root));
  fat32_le_capture #(.OFFSET(OFF_PTYPE), .NBYTES(1), .CNT_W(CNT_W)) u_cap_ptype (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(w_start_ok), .i_en(w_cap_en),
    .i_cnt(r_cnt), .i_byte(i_byte_in), .o_field(w_ptype));
  fat32_le_capture #(.OFFSET(OFF_PLBA),  .NBYTES(4), .CNT_W(CNT_W)) u_cap_plba (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(w_start_ok), .i_en(w_cap_en),
    .i_cnt(r_cnt), .i_byte(i_byte_in), .o_field(w_plba));
  fat32_le_capture #(.OFFSET(OFF_SIG),   .NBYTES(2), .CNT_W(CNT_W)) u_cap_sig (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(w_start_ok), .i_en(w_cap_en),
    .i_cnt(r_cnt), .i_byte(i_byte_in), .o_field(w_sig));

  // Block validation: the first failing test in priority order wins
  always_comb begin
    w_chk_code = ERR_NONE;
    if (r_cnt < CNT_FULL) begin
      w_chk_code = ERR_SHORT;
    end else if (w_sig != BOOT_SIG) begin
      w_chk_code = ERR_SIG;
    end else if (!r_mode) begin
      if ((w_ptype != PTYPE_FAT32_CHS) && (w_ptype != PTYPE_FAT32_LBA)) begin
        w_chk_code = ERR_PTYPE;
      end else begin
        w_chk_code = ERR_NONE;
      end
    end else if (w_bps != BPS_REQ) begin
      w_chk_code = ERR_BPS;
    end else if (!is_pow2(w_spc)) begin
      w_chk_code = ERR_SPC;
    end else if ((w_nfats != 8'd1) && (w_nfats != 8'd2)) begin
      w_chk_code = ERR_NFATS;
    end else begin
      w_chk_code = ERR_NONE;
    end
  end

  // Single shared adder. The reserved-sector add runs during CHECK, so VBR
  // done lands 3 (one FAT) or 4 (two FATs) cycles after block_done.
  always_comb begin
    w_add_a = 32'd0;
    w_add_b = 32'd0;
    case (r_state)
      ST_CHECK: begin
        w_add_a = o_part_lba;
        w_add_b = {16'd0, w_rsvd};
      end
      ST_CALC_D1: begin
        w_add_a = r_fat;
        w_add_b = w_fatsz;
      end
      ST_CALC_D2: begin
        w_add_a = r_data;
        w_add_b = w_fatsz;
      end
      default: begin
        w_add_a = 32'd0;
        w_add_b = 32'd0;
      end
    endcase
  end

  assign w_sum = w_add_a + w_add_b;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_RECV;
        else            w_state_nxt = ST_IDLE;
      end
      ST_RECV: begin
        // A coincident byte is counted first; CHECK sees the updated count
        if (i_block_done) w_state_nxt = ST_CHECK;
        else              w_state_nxt = ST_RECV;
      end
      ST_CHECK: begin
        if (w_chk_code != ERR_NONE) w_state_nxt = ST_ERR;
        else if (!r_mode)           w_state_nxt = ST_FIN;
        else                        w_state_nxt = ST_CALC_D1;
      end
      ST_CALC_D1: begin
        if (w_nfats == 8'd2) w_state_nxt = ST_CALC_D2;
        else                 w_state_nxt = ST_FIN;
      end
      ST_CALC_D2: begin
        w_state_nxt = ST_FIN;
      end
      ST_FIN, ST_ERR: begin
        if (w_start_ok) w_state_nxt = ST_RECV;
        else            w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Busy covers every state between an accepted start and the result pulse
  always_comb begin
    case (w_state_nxt)
      ST_RECV, ST_CHECK, ST_CALC_D1, ST_CALC_D2: w_busy_nxt = 1'b1;
      default:                                   w_busy_nxt = 1'b0;
    endcase
  end

  // State, counter, work registers and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= ST_IDLE;
      r_mode           <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_error          <= 1'b0;
      r_cnt            <= '0;
      r_fat            <= 32'd0;
      r_data           <= 32'd0;
      o_err_code       <= ERR_NONE;
      o_part_lba       <= 32'd0;
      o_sec_per_clus   <= 8'd0;
      o_fat_start_lba  <= 32'd0;
      o_data_start_lba <= 32'd0;
      o_root_cluster   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= 1'b0;
      r_error <= 1'b0;

      if (w_start_ok) begin
        r_mode     <= i_mode;
        r_cnt      <= '0;
        o_err_code <= ERR_NONE;
      end else if (w_cap_en) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_state == ST_CHECK) begin
        r_fat <= w_sum;
      end
      if ((r_state == ST_CALC_D1) || (r_state == ST_CALC_D2)) begin
        r_data <= w_sum;
      end

      // Results are published on the edge into FIN, alongside done
      if (w_state_nxt == ST_FIN) begin
        r_done <= 1'b1;
        if (!r_mode) begin
          o_part_lba <= w_plba;
        end else begin
          o_sec_per_clus   <= w_spc;
          o_fat_start_lba  <= r_fat;
          o_data_start_lba <= w_sum;
          o_root_cluster   <= w_root;
        end
      end

      if (w_state_nxt == ST_ERR) begin
        r_error    <= 1'b1;
        o_err_code <= w_chk_code;
      end
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_error = r_error;

endmodule

// File: tb/tb_fat32_volume_parser.sv
// -----------------------------------------------------------------------------
// tb_fat32_volume_parser
//   Directed and randomized parses of MBR / VBR blocks. Expected results come
//   from a block-level reference model that evaluates the boot-record rules
//   directly on the byte array.
// -----------------------------------------------------------------------------
module tb_fat32_volume_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        block_done = 1'b0;
  logic        busy, done, error;
  logic [2:0]  err_code;
  logic [31:0] part_lba, fat_start_lba, data_start_lba, root_cluster;
  logic [7:0]  sec_per_clus;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  blk [0:511];
  logic [31:0] m_part = 32'd0;
  logic [31:0] m_fat  = 32'd0;
  logic [31:0] m_data = 32'd0;
  logic [31:0] m_root = 32'd0;
  logic [7:0]  m_spc  = 8'd0;

  fat32_volume_parser #(.BLOCK_BYTES(512)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_byte_in(byte_in), .i_byte_valid(byte_valid), .i_block_done(block_done),
    .o_busy(busy), .o_done(done), .o_error(error), .o_err_code(err_code),
    .o_part_lba(part_lba), .o_sec_per_clus(sec_per_clus),
    .o_fat_start_lba(fat_start_lba), .o_data_start_lba(data_start_lba),
    .o_root_cluster(root_cluster));

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic put(input int off, input int n, input logic [31:0] v);
    logic [31:0] t;
    t = v;
    for (int k = 0; k < n; k++) begin
      blk[off + k] = t[7:0];
      t = t >> 8;
    end
  endtask

  function automatic longint unsigned le(input int off, input int n);
    longint unsigned v;
    v = 0;
    for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(blk[off + k]);
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
    blk[510] = 8'h55;
    blk[511] = 8'hAA;
  endtask

  task automatic fill_mbr(input logic [7:0] ptype, input logic [31:0] lba);
    fill_random();
    blk[450] = ptype;
    put(454, 4, lba);
  endtask

  task automatic fill_vbr(input logic [7:0] spc, input logic [15:0] rsvd, input logic [7:0] nf,
                          input logic [31:0] fsz, input logic [31:0] root);
    fill_random();
    put(11, 2, 32'd512);
    blk[13] = spc;
    put(14, 2, {16'd0, rsvd});
    blk[16] = nf;
    put(36, 4, fsz);
    put(44, 4, root);
  endtask

  // Reference model: applies the rules to the block, updates held results
  task automatic model_eval(input bit md, input int nbytes, output logic [2:0] e, output int lat);
    int bps, nf;
    e = 3'd0;
    lat = 0;
    bps = int'(le(11, 2));
    nf  = int'(blk[16]);
    if (nbytes < 512) e = 3'd1;
    else if (blk[510] != 8'h55 || blk[511] != 8'hAA) e = 3'd2;
    else if (!md) begin
      if (!(blk[450] == 8'h0B || blk[450] == 8'h0C)) e = 3'd3;
    end
    else if (bps != 512) e = 3'd4;
    else if ($countones(blk[13]) != 1) e = 3'd5;
    else if (nf != 1 && nf != 2) e = 3'd6;
    if (e == 3'd0) begin
      if (!md) begin
        m_part = 32'(le(454, 4));
        lat = 2;
      end else begin
        m_fat  = 32'(longint'(m_part) + longint'(le(14, 2)));
        m_data = 32'(longint'(m_fat) + longint'(nf) * longint'(le(36, 4)));
        m_root = 32'(le(44, 4));
        m_spc  = blk[13];
        lat = 2 + nf;
      end
    end
  endtask

  task automatic run(input bit md, input int nbytes, input bit coincide, input bit extra_start,
                     input string tag);
    int nsend, k;
    bit got;
    logic [2:0] e;
    int lat;
    start = 1'b1;
    mode = md;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    nsend = coincide ? nbytes - 1 : nbytes;
    for (int i = 0; i < nsend; i++) begin
      if ($urandom_range(3, 0) == 0) @(negedge clk);
      byte_in = (i < 512) ? blk[i] : 8'($urandom);
      byte_valid = 1'b1;
      if (extra_start && i == 100) begin
        start = 1'b1;
        mode = ~md;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      start = 1'b0;
      mode = md;
    end
    if (!coincide) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end else begin
      byte_in = (nbytes - 1 < 512) ? blk[nbytes - 1] : 8'($urandom);
      byte_valid = 1'b1;
    end
    block_done = 1'b1;
    k = 0;
    got = 1'b0;
    while (k < 20 && !got) begin
      @(negedge clk);
      byte_valid = 1'b0;
      block_done = 1'b0;
      k++;
      if (done || error) got = 1'b1;
    end
    model_eval(md, nbytes, e, lat);
    chk({tag, "_pulse"}, {30'd0, done, error}, (e == 3'd0) ? 32'd2 : 32'd1);
    if (e == 3'd0) chk({tag, "_lat"}, 32'(k), 32'(lat));
    chk({tag, "_err"}, {29'd0, err_code}, {29'd0, e});
    chk({tag, "_part"}, part_lba, m_part);
    chk({tag, "_spc"}, {24'd0, sec_per_clus}, {24'd0, m_spc});
    chk({tag, "_fat"}, fat_start_lba, m_fat);
    chk({tag, "_data"}, data_start_lba, m_data);
    chk({tag, "_root"}, root_cluster, m_root);
    @(negedge clk);
    chk({tag, "_after"}, {29'd0, done, error, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    int c, nb;
    bit md;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_err_code", {29'd0, err_code}, 32'd0);
    chk("rst_part", part_lba, 32'd0);
    chk("rst_spc", {24'd0, sec_per_clus}, 32'd0);
    chk("rst_fat", fat_start_lba, 32'd0);
    chk("rst_data", data_start_lba, 32'd0);
    chk("rst_root", root_cluster, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // MBR, type 0x0C
    fill_mbr(8'h0C, 32'h0000_2000);
    run(1'b0, 512, 1'b0, 1'b0, "t1");
    chk("t1_part_const", part_lba, 32'h0000_2000);

    // VBR with two FATs on top of part_lba 0x2000
    fill_vbr(8'd8, 16'd32, 8'd2, 32'h0000_03C1, 32'd2);
    run(1'b1, 512, 1'b0, 1'b0, "t2");
    chk("t2_fat_const", fat_start_lba, 32'h0000_2020);
    chk("t2_data_const", data_start_lba, 32'h0000_27A2);
    chk("t2_root_const", root_cluster, 32'd2);

    // Bad signature byte
    fill_vbr(8'd4, 16'd10, 8'd1, 32'h100, 32'd5);
    blk[511] = 8'h00;
    run(1'b1, 512, 1'b0, 1'b0, "t3");

    // Short block, then last byte coincident with block_done
    fill_vbr(8'd4, 16'd10, 8'd1, 32'h100, 32'd5);
    run(1'b1, 300, 1'b0, 1'b0, "t4a");
    fill_vbr(8'd16, 16'd64, 8'd1, 32'h1234, 32'd7);
    run(1'b1, 512, 1'b1, 1'b0, "t4b");

    // Bad sec_per_clus, bad num_fats, start pulsed during RECV
    fill_vbr(8'd6, 16'd32, 8'd2, 32'h3C1, 32'd2);
    run(1'b1, 512, 1'b0, 1'b0, "t5a");
    fill_vbr(8'd8, 16'd32, 8'd3, 32'h3C1, 32'd2);
    run(1'b1, 512, 1'b0, 1'b0, "t5b");
    fill_vbr(8'd32, 16'd100, 8'd2, 32'h7777, 32'd9);
    run(1'b1, 512, 1'b0, 1'b1, "t5c");

    // Reset in the middle of a parse
    fill_vbr(8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2);
    start = 1'b1;
    mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      byte_in = blk[i];
      byte_valid = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_flags", {29'd0, done, error, busy}, 32'd0);
    chk("t6_part", part_lba, 32'd0);
    chk("t6_fat", fat_start_lba, 32'd0);
    chk("t6_data", data_start_lba, 32'd0);
    chk("t6_root", root_cluster, 32'd0);
    chk("t6_spc", {24'd0, sec_per_clus}, 32'd0);
    rst = 1'b0;
    m_part = 32'd0; m_fat = 32'd0; m_data = 32'd0; m_root = 32'd0; m_spc = 8'd0;
    c = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || error || busy) c++;
    end
    chk("t6_quiet", 32'(c), 32'd0);
    fill_mbr(8'h0B, 32'h0001_0000);
    run(1'b0, 512, 1'b0, 1'b0, "t6_mbr");
    fill_vbr(8'd1, 16'd6, 8'd2, 32'h200, 32'd3);
    run(1'b1, 512, 1'b0, 1'b0, "t6_vbr");

    // Randomized parses, some corrupted, some with trailing extra bytes
    for (int it = 0; it < 20; it++) begin
      md = 1'($urandom_range(1, 0));
      c  = $urandom_range(7, 0);
      nb = ($urandom_range(3, 0) == 0) ? 512 + $urandom_range(8, 1) : 512;
      if (!md) begin
        fill_mbr(($urandom_range(1, 0) != 0) ? 8'h0B : 8'h0C, $urandom);
        if (c == 1) begin
          v = 8'($urandom);
          if (v == 8'h0B || v == 8'h0C) v = 8'h07;
          blk[450] = v;
        end
      end else begin
        fill_vbr(8'(1 << $urandom_range(7, 0)), 16'($urandom), 8'($urandom_range(2, 1)),
                 $urandom, $urandom);
        if (c == 1) begin
          v = 8'($urandom);
          put(11, 2, {16'd0, v, 8'($urandom_range(255, 1))});
        end else if (c == 2) begin
          v = 8'($urandom);
          if ($countones(v) == 1) v = v | 8'h81;
          if ($urandom_range(3, 0) == 0) v = 8'd0;
          blk[13] = v;
        end else if (c == 3) begin
          blk[16] = ($urandom_range(1, 0) != 0) ? 8'd0 : 8'($urandom_range(255, 3));
        end
      end
      if (c == 0) blk[510 + $urandom_range(1, 0)] = 8'h00;
      if (c == 4) nb = $urandom_range(511, 1);
      run(md, nb, 1'($urandom_range(1, 0)), 1'b0, $sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
